// File: rtl/key_deposit_pkg.sv
// Shared PHV/key geometry for the key extract and key deposit blocks.
package key_deposit_pkg;

    localparam int CONT_W     = 32;   // container width in bits
    localparam int NUM_CONT   = 64;   // 4B containers in the PHV
    localparam int META_W     = 256;  // metadata bits below the containers
    localparam int SLOT_OFF_W = 6;    // container index width per slot

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_OUT   = 2'd2
    } dep_state_t;

    // LSB of container c; container 63 sits at the top of the PHV.
    function automatic int cont_lsb(input int c);
        return META_W + c * CONT_W;
    endfunction

    // MSB of value slot i inside the value vector (slot 0 at the top).
    function automatic int slot_val_msb(input int key_len, input int i);
        return key_len - 1 - CONT_W * i;
    endfunction

    // MSB of offset slot i inside the offset vector (slot 0 at the top).
    function automatic int slot_off_msb(input int off_len, input int i);
        return off_len - 1 - SLOT_OFF_W * i;
    endfunction

endpackage

// File: rtl/key_deposit_cont_writer.sv
// One PHV container: replaces the original word with the highest-index
// enabled slot value that targets this container.
module phv_cont_writer
    import key_deposit_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic [CONT_W-1:0]                     orig_i,
    input  logic [SLOT_OFF_W-1:0]                 cont_idx_i,
    input  logic [NUM_SLOTS-1:0][CONT_W-1:0]      slot_val_i,
    input  logic [NUM_SLOTS-1:0][SLOT_OFF_W-1:0]  slot_off_i,
    input  logic [NUM_SLOTS-1:0]                  slot_en_i,
    output logic [CONT_W-1:0]                     word_o
);

    // Ascending scan so later (higher-index) slots overwrite earlier ones.
    always_comb begin
        word_o = orig_i;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_en_i[i] && (slot_off_i[i] == cont_idx_i)) begin
                word_o = slot_val_i[i];
            end
        end
    end

endmodule

// File: rtl/key_deposit.sv
// Key deposit: scatters up to NUM_SLOTS action result words into PHV
// containers, then holds the modified PHV until downstream accepts it.
module key_deposit
    import key_deposit_pkg::*;
#(
    parameter int STAGE_ID  = 0,
    parameter int PHV_LEN   = 4*8*64+256,
    parameter int KEY_LEN   = 4*8*8+1,
    parameter int KEY_OFF   = 8*6+20,
    parameter int NUM_SLOTS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PHV_LEN-1:0]   phv_in,
    input  logic                 phv_valid_in,
    input  logic [KEY_LEN-1:0]   val_in,
    input  logic [KEY_OFF-1:0]   val_offset_in,
    input  logic [NUM_SLOTS-1:0] val_wen_in,
    output logic                 ready_out,
    output logic [PHV_LEN-1:0]   phv_out,
    output logic                 phv_valid_out,
    input  logic                 ready_in
);

    localparam int OFF_USED_W = NUM_SLOTS * SLOT_OFF_W;
    localparam int unused_stage_id = STAGE_ID;

    dep_state_t             state_q;
    logic [PHV_LEN-1:0]     phv_q;
    logic [KEY_LEN-1:0]     val_q;
    logic [OFF_USED_W-1:0]  off_q;
    logic [NUM_SLOTS-1:0]   wen_q;
    logic [PHV_LEN-1:0]     phv_out_q;
    logic                   phv_valid_out_q;
    logic                   ready_out_q;
    logic [PHV_LEN-1:0]     phv_d;

    logic [NUM_SLOTS-1:0][CONT_W-1:0]     slot_val;
    logic [NUM_SLOTS-1:0][SLOT_OFF_W-1:0] slot_off;
    logic [NUM_SLOTS-1:0]                 slot_en;

    // Low offset bits are reserved and deliberately ignored.
    logic unused_off_bits;
    assign unused_off_bits = ^val_offset_in[KEY_OFF-OFF_USED_W-1:0];

    // Unpack captured slots; slot i enable lives at wen bit NUM_SLOTS-1-i
    // and is gated by the value-vector valid bit.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign slot_val[gi] = val_q[slot_val_msb(KEY_LEN, gi) -: CONT_W];
        assign slot_off[gi] = off_q[slot_off_msb(OFF_USED_W, gi) -: SLOT_OFF_W];
        assign slot_en[gi]  = wen_q[NUM_SLOTS-1-gi] & val_q[0];
    end

    // Metadata is forwarded as-is.
    assign phv_d[META_W-1:0] = phv_q[META_W-1:0];

    for (genvar gi = 0; gi < NUM_CONT; gi++) begin : g_cont
        phv_cont_writer #(
            .NUM_SLOTS (NUM_SLOTS)
        ) u_writer (
            .orig_i     (phv_q[cont_lsb(gi) +: CONT_W]),
            .cont_idx_i (SLOT_OFF_W'(gi)),
            .slot_val_i (slot_val),
            .slot_off_i (slot_off),
            .slot_en_i  (slot_en),
            .word_o     (phv_d[cont_lsb(gi) +: CONT_W])
        );
    end

    // Control FSM: capture in IDLE, register scattered PHV in APPLY, hold in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            phv_q           <= '0;
            val_q           <= '0;
            off_q           <= '0;
            wen_q           <= '0;
            phv_out_q       <= '0;
            phv_valid_out_q <= 1'b0;
            ready_out_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (phv_valid_in) begin
                        phv_q       <= phv_in;
                        val_q       <= val_in;
                        off_q       <= val_offset_in[KEY_OFF-1 -: OFF_USED_W];
                        wen_q       <= val_wen_in;
                        ready_out_q <= 1'b0;
                        state_q     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    phv_out_q       <= phv_d;
                    phv_valid_out_q <= 1'b1;
                    state_q         <= ST_OUT;
                end
                ST_OUT: begin
                    if (ready_in) begin
                        phv_valid_out_q <= 1'b0;
                        ready_out_q     <= 1'b1;
                        state_q         <= ST_IDLE;
                    end
                end
                default: begin
                    phv_valid_out_q <= 1'b0;
                    ready_out_q     <= 1'b1;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_out     = ready_out_q;
    assign phv_out       = phv_out_q;
    assign phv_valid_out = phv_valid_out_q;

endmodule

// File: tb/tb_key_deposit.sv
// Self-checking bench for key_deposit: scoreboard of expected PHVs pushed on
// acceptance and popped when phv_valid_out rises.
module tb_key_deposit;

    localparam int PHV_LEN = 4*8*64+256;
    localparam int KEY_LEN = 4*8*8+1;
    localparam int KEY_OFF = 8*6+20;
    localparam int NS      = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic [KEY_LEN-1:0] val_in;
    logic [KEY_OFF-1:0] val_offset_in;
    logic [NS-1:0]      val_wen_in;
    logic               ready_out;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic               ready_in;

    int checks = 0;
    int errors = 0;
    logic [PHV_LEN-1:0] exp_q[$];

    key_deposit dut (
        .clk           (clk),
        .rst           (rst),
        .phv_in        (phv_in),
        .phv_valid_in  (phv_valid_in),
        .val_in        (val_in),
        .val_offset_in (val_offset_in),
        .val_wen_in    (val_wen_in),
        .ready_out     (ready_out),
        .phv_out       (phv_out),
        .phv_valid_out (phv_valid_out),
        .ready_in      (ready_in)
    );

    always #5 clk = ~clk;

    // Reference scatter: slots applied in ascending order, so the last enabled slot wins.
    function automatic logic [PHV_LEN-1:0] model(input logic [PHV_LEN-1:0] p,
                                                 input logic [KEY_LEN-1:0] v,
                                                 input logic [KEY_OFF-1:0] o,
                                                 input logic [NS-1:0] w);
        logic [PHV_LEN-1:0] r;
        r = p;
        if (v[0]) begin
            for (int i = 0; i < NS; i++) begin
                if (w[NS-1-i]) begin
                    int c;
                    c = int'(o[KEY_OFF-1-6*i -: 6]);
                    r[256+32*c +: 32] = v[KEY_LEN-1-32*i -: 32];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [PHV_LEN-1:0] rand_phv();
        logic [PHV_LEN-1:0] r;
        for (int k = 0; k < PHV_LEN/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] cont(input logic [PHV_LEN-1:0] p, input int c);
        return p[256+32*c +: 32];
    endfunction

    // Offsets packed with slot 0 at the top; reserved low bits filled with noise.
    function automatic logic [KEY_OFF-1:0] mk_off(input int offs[NS]);
        logic [KEY_OFF-1:0] o;
        o = '0;
        o[19:0] = 20'($urandom);
        for (int i = 0; i < NS; i++) o[KEY_OFF-1-6*i -: 6] = 6'(offs[i]);
        return o;
    endfunction

    function automatic logic [KEY_LEN-1:0] mk_val(input logic [31:0] vals[NS], input logic vbit);
        logic [KEY_LEN-1:0] v;
        v = '0;
        v[0] = vbit;
        for (int i = 0; i < NS; i++) v[KEY_LEN-1-32*i -: 32] = vals[i];
        return v;
    endfunction

    // Present one PHV for exactly one accepting cycle and push its expected result.
    task automatic send(input logic [PHV_LEN-1:0] p, input logic [KEY_LEN-1:0] v,
                        input logic [KEY_OFF-1:0] o, input logic [NS-1:0] w);
        int n;
        n = 0;
        while (!ready_out && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!ready_out) begin
            checks++; errors++;
            $display("FAIL send_ready timeout: ready_out=%0b required 1", ready_out);
        end
        @(negedge clk);
        phv_in = p; val_in = v; val_offset_in = o; val_wen_in = w;
        phv_valid_in = 1'b1;
        exp_q.push_back(model(p, v, o, w));
        @(posedge clk); #1;
        phv_valid_in = 1'b0;
    endtask

    // Count clock edges (after the accepting edge) until phv_valid_out rises.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!phv_valid_out && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [PHV_LEN-1:0] e;
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (phv_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", phv_valid_out); end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready_out); end
        checks++;
        if (phv_out !== '0) begin errors++; $display("FAIL reset_phv got nonzero want 0"); end
        @(negedge clk); rst = 1'b0;
        // Reset while holding a result in OUT.
        send(rand_phv(), mk_val('{default:32'h12345678}, 1'b1), mk_off('{0,1,2,3,4,5,6,7}), 8'hFF);
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++;
        if (phv_valid_out !== 1'b1 || phv_out !== e) begin
            errors++; $display("FAIL reset_pre_out valid=%0b data_ok=%0b want valid 1 data_ok 1", phv_valid_out, phv_out === e);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (phv_valid_out !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got %0b want 0", phv_valid_out); end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %0b want 1", ready_out); end
        checks++;
        if (phv_out !== '0) begin errors++; $display("FAIL reset_mid_phv got nonzero want 0"); end
        $display("txn reset: mid-OUT reset done");
    endtask

    task automatic test_single_write();
        logic [PHV_LEN-1:0] p, e;
        logic [31:0] vals[NS];
        int offs[NS];
        int lat;
        p = rand_phv();
        vals = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        offs = '{5, 9, 9, 9, 9, 9, 9, 9};
        send(p, mk_val(vals, 1'b1), mk_off(offs), 8'h80);
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL single_latency got %0d edges want 1", lat); end
        e = exp_q.pop_front();
        checks++;
        if (phv_out !== e) begin errors++; $display("FAIL single_phv got cont5=%h want %h", cont(phv_out, 5), cont(e, 5)); end
        checks++;
        if (cont(phv_out, 5) !== 32'hDEADBEEF || cont(phv_out, 9) !== cont(p, 9)) begin
            errors++; $display("FAIL single_cont got c5=%h c9=%h want c5=deadbeef c9=%h", cont(phv_out, 5), cont(phv_out, 9), cont(p, 9));
        end
        $display("txn single: cont5=%h latency=%0d", cont(phv_out, 5), lat);
        release_out();
    endtask

    task automatic test_collision();
        logic [PHV_LEN-1:0] e;
        logic [31:0] vals[NS];
        int offs[NS];
        int lat;
        vals = '{32'h0, 32'h11111111, 32'h0, 32'h0, 32'h0, 32'h0, 32'h66666666, 32'h0};
        offs = '{0, 10, 0, 0, 0, 0, 10, 0};
        send(rand_phv(), mk_val(vals, 1'b1), mk_off(offs), 8'h42);
        wait_valid(lat);
        e = exp_q.pop_front();
        checks++;
        if (cont(phv_out, 10) !== 32'h66666666) begin
            errors++; $display("FAIL collision_cont10 got %h want 66666666", cont(phv_out, 10));
        end
        checks++;
        if (phv_out !== e) begin errors++; $display("FAIL collision_phv got c0=%h want %h", cont(phv_out, 0), cont(e, 0)); end
        $display("txn collision: cont10=%h", cont(phv_out, 10));
        release_out();
    endtask

    task automatic test_disabled();
        logic [PHV_LEN-1:0] p;
        logic [31:0] vals[NS];
        int offs[NS];
        int lat;
        vals = '{default:32'hA5A5A5A5};
        offs = '{1, 2, 3, 4, 5, 6, 7, 8};
        for (int k = 0; k < 2; k++) begin
            p = rand_phv();
            if (k == 0) send(p, mk_val(vals, 1'b1), mk_off(offs), 8'h00);
            else        send(p, mk_val(vals, 1'b0), mk_off(offs), 8'hFF);
            wait_valid(lat);
            void'(exp_q.pop_front());
            checks++;
            if (phv_out !== p) begin
                errors++; $display("FAIL disabled_%0d got c1=%h meta=%h want c1=%h meta=%h", k, cont(phv_out, 1), phv_out[31:0], cont(p, 1), p[31:0]);
            end
            $display("txn disabled_%0d: passthrough c1=%h", k, cont(phv_out, 1));
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [PHV_LEN-1:0] e, snap, p2;
        logic [31:0] vals[NS];
        int offs[NS];
        int lat;
        vals = '{default:32'hCAFEF00D};
        offs = '{11, 12, 13, 14, 15, 16, 17, 18};
        send(rand_phv(), mk_val(vals, 1'b1), mk_off(offs), 8'hF0);
        wait_valid(lat);
        e = exp_q.pop_front();
        snap = phv_out;
        checks++;
        if (snap !== e) begin errors++; $display("FAIL bp_data got c11=%h want %h", cont(snap, 11), cont(e, 11)); end
        // Offer a second PHV while stalled; it must be ignored.
        p2 = rand_phv();
        @(negedge clk);
        phv_in = p2; val_in = mk_val(vals, 1'b1); val_offset_in = mk_off(offs); val_wen_in = 8'hFF;
        phv_valid_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (phv_out !== snap || ready_out !== 1'b0 || phv_valid_out !== 1'b1) begin
                errors++; $display("FAIL bp_hold cycle %0d stable=%0b ready=%0b valid=%0b want 1 0 1", c, phv_out === snap, ready_out, phv_valid_out);
            end
        end
        phv_valid_in = 1'b0;
        release_out();
        checks++;
        if (ready_out !== 1'b1 || phv_valid_out !== 1'b0) begin
            errors++; $display("FAIL bp_release ready=%0b valid=%0b want 1 0", ready_out, phv_valid_out);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_queue got %0d want 0", exp_q.size()); end
        $display("txn backpressure: held 5 cycles");
    endtask

    task automatic test_round_trip();
        logic [PHV_LEN-1:0] p;
        logic [31:0] vals[NS];
        int offs[NS];
        int lat;
        p = rand_phv();
        offs = '{0, 63, 7, 20, 33, 41, 50, 12};
        for (int i = 0; i < NS; i++) vals[i] = cont(p, offs[i]);
        send(p, mk_val(vals, 1'b1), mk_off(offs), 8'hFF);
        wait_valid(lat);
        void'(exp_q.pop_front());
        checks++;
        if (phv_out !== p) begin errors++; $display("FAIL round_trip got c63=%h want %h", cont(phv_out, 63), cont(p, 63)); end
        $display("txn round_trip: c0=%h c63=%h", cont(phv_out, 0), cont(phv_out, 63));
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [PHV_LEN-1:0] e;
        logic [31:0] vals[NS];
        int offs[NS];
        int lat;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NS; i++) begin
                vals[i] = $urandom;
                offs[i] = $urandom_range(0, 63);
            end
            send(rand_phv(), mk_val(vals, 1'($urandom_range(0, 3) != 0)), mk_off(offs), 8'($urandom));
            wait_valid(lat);
            e = exp_q.pop_front();
            checks++;
            if (phv_out !== e || lat !== 1) begin
                errors++; $display("FAIL b2b_%0d data_ok=%0b latency=%0d want data_ok 1 latency 1", t, phv_out === e, lat);
            end
            $display("txn b2b_%0d: c%0d=%h", t, offs[NS-1], cont(phv_out, offs[NS-1]));
            release_out();
        end
    endtask

    initial begin
        phv_in = '0; phv_valid_in = 1'b0; val_in = '0; val_offset_in = '0;
        val_wen_in = '0; ready_in = 1'b0; rst = 1'b1;
        test_reset();
        test_single_write();
        test_collision();
        test_disabled();
        test_backpressure();
        test_round_trip();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
